// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The master drives operands and accepts results; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             illegal_operation;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, overflow, illegal_operation
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, overflow, illegal_operation
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: add, equality, sequential shift-add multiply, illegal-op flag.
// One operation in flight; multiply walks b LSB first, one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic [2*WIDTH-1:0] acc_sum;

    // Sum with carry kept as the extra top bit.
    function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Next-state and datapath update; outputs are registered so they hold under backpressure.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        acc_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ill_d = 1'b0;
                    ovf_d = 1'b0;
                    acc_d = '0;
                    cnt_d = '0;
                    case (bus.opcode)
                        2'b00: begin
                            {ovf_d, result_d} = add_carry(bus.a, bus.b);
                            state_d = DONE;
                        end
                        2'b01: begin
                            result_d = {WIDTH{bus.a == bus.b}};
                            state_d  = DONE;
                        end
                        2'b10: begin
                            mcand_d = {{WIDTH{1'b0}}, bus.a};
                            mplr_d  = bus.b;
                            state_d = MUL;
                        end
                        default: begin
                            result_d = '1;
                            ill_d    = 1'b1;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = acc_sum[WIDTH-1:0];
                    ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign bus.in_ready          = (state_q == IDLE);
    assign bus.out_valid         = (state_q == DONE);
    assign bus.result            = result_q;
    assign bus.overflow          = ovf_q;
    assign bus.illegal_operation = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=5 and WIDTH=8.
module tb_alu_seq;
    logic clk;
    logic rst_n;

    alu_seq_if #(.WIDTH(5)) b5 ();
    alu_seq_if #(.WIDTH(8)) b8 ();

    alu_seq #(.WIDTH(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5));
    alu_seq #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct {
        int unsigned res;
        bit          ovf;
        bit          ill;
    } exp_t;

    exp_t q5[$];
    exp_t q8[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference behaviour computed on full-width integers.
    function automatic exp_t model(input int w, input int unsigned a, input int unsigned b,
                                   input logic [1:0] op);
        exp_t e;
        longint unsigned full;
        longint unsigned mask;
        mask  = (64'd1 << w) - 64'd1;
        e.ill = 1'b0;
        case (op)
            2'b00:   full = 64'(a) + 64'(b);
            2'b01:   full = (a == b) ? mask : 64'd0;
            2'b10:   full = 64'(a) * 64'(b);
            default: begin full = mask; e.ill = 1'b1; end
        endcase
        e.res = 32'(full & mask);
        e.ovf = ((full >> w) != 64'd0);
        return e;
    endfunction

    // Pop and compare whenever a result transfers.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b5.out_valid && b5.out_ready) begin
            if (q5.size() == 0) chk("sb5_unexpected", 32'(b5.result), 32'hFFFF_FFFF);
            else begin
                e = q5.pop_front();
                chk("res5", 32'(b5.result), e.res);
                chk("ovf5", 32'(b5.overflow), 32'(e.ovf));
                chk("ill5", 32'(b5.illegal_operation), 32'(e.ill));
            end
        end
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) chk("sb8_unexpected", 32'(b8.result), 32'hFFFF_FFFF);
            else begin
                e = q8.pop_front();
                chk("res8", 32'(b8.result), e.res);
                chk("ovf8", 32'(b8.overflow), 32'(e.ovf));
                chk("ill8", 32'(b8.illegal_operation), 32'(e.ill));
            end
        end
    end

    task automatic op5(input int unsigned a, input int unsigned b, input logic [1:0] op);
        int lat;
        @(posedge clk); #1;
        b5.in_valid = 1'b1; b5.a = a[4:0]; b5.b = b[4:0]; b5.opcode = op;
        q5.push_back(model(5, a, b, op));
        @(negedge clk);
        chk("in_ready5", 32'(b5.in_ready), 1);
        @(posedge clk); #1;
        b5.in_valid = 1'b0; b5.a = ~b5.a; b5.b = 5'($urandom); b5.opcode = ~op;
        lat = 1;
        @(negedge clk);
        while (!b5.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("lat5", 32'(lat), (op == 2'b10) ? 6 : 1);
        @(posedge clk); #1;
        chk("idle5", 32'({b5.out_valid, b5.in_ready}), 1);
    endtask

    task automatic op8(input int unsigned a, input int unsigned b, input logic [1:0] op);
        int lat;
        @(posedge clk); #1;
        b8.in_valid = 1'b1; b8.a = a[7:0]; b8.b = b[7:0]; b8.opcode = op;
        q8.push_back(model(8, a, b, op));
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom);
        lat = 1;
        @(negedge clk);
        while (!b8.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("lat8", 32'(lat), (op == 2'b10) ? 9 : 1);
        @(posedge clk); #1;
        chk("idle8", 32'({b8.out_valid, b8.in_ready}), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        b5.in_valid = 1'b0; b5.a = '0; b5.b = '0; b5.opcode = '0; b5.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.opcode = '0; b8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(b5.in_ready), 1);
        chk("rst_out_valid", 32'(b5.out_valid), 0);
        chk("rst_result", 32'(b5.result), 0);
        chk("rst_ovf", 32'(b5.overflow), 0);
        chk("rst_ill", 32'(b5.illegal_operation), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // add, wrap, multiply, equal, illegal
        op5(3, 4, 2'b00);
        op5(20, 15, 2'b00);
        op5(31, 1, 2'b00);
        op5(5, 6, 2'b10);
        op5(7, 5, 2'b10);
        op5(0, 31, 2'b10);
        op5(31, 31, 2'b10);
        op5(9, 9, 2'b01);
        op5(9, 8, 2'b01);
        op5(12, 3, 2'b11);
        for (int i = 0; i < 8; i++) begin
            op5($urandom_range(0, 31), $urandom_range(0, 31), 2'($urandom_range(0, 3)));
        end

        // backpressure with a second request held during DONE
        @(posedge clk); #1;
        b5.out_ready = 1'b0;
        b5.in_valid = 1'b1; b5.a = 5'd10; b5.b = 5'd11; b5.opcode = 2'b00;
        q5.push_back(model(5, 10, 11, 2'b00));
        @(posedge clk); #1;
        b5.a = 5'd1; b5.b = 5'd2; b5.opcode = 2'b00;
        q5.push_back(model(5, 1, 2, 2'b00));
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid", 32'(b5.out_valid), 1);
            chk("bp_busy", 32'(b5.in_ready), 0);
            chk("bp_hold_res", 32'(b5.result), 21);
            chk("bp_hold_ovf", 32'(b5.overflow), 0);
        end
        @(posedge clk); #1;
        b5.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_no_passthru", 32'({b5.out_valid, b5.in_ready}), 1);
        @(posedge clk); #1;
        b5.in_valid = 1'b0;
        chk("bp_second_valid", 32'(b5.out_valid), 1);
        @(posedge clk); #1;
        chk("bp_idle", 32'({b5.out_valid, b5.in_ready}), 1);

        // reset two cycles into a multiply
        b5.in_valid = 1'b1; b5.a = 5'd5; b5.b = 5'd6; b5.opcode = 2'b10;
        @(posedge clk); #1;
        b5.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mulbusy_before_rst", 32'(b5.in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rstmul_out_valid", 32'(b5.out_valid), 0);
        chk("rstmul_in_ready", 32'(b5.in_ready), 1);
        chk("rstmul_result", 32'(b5.result), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rstmul_no_stale", 32'(b5.out_valid), 0);

        // reset while a result is waiting in DONE
        b5.out_ready = 1'b0;
        b5.in_valid = 1'b1; b5.a = 5'd31; b5.b = 5'd31; b5.opcode = 2'b11;
        @(posedge clk); #1;
        b5.in_valid = 1'b0;
        chk("done_wait_valid", 32'(b5.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rstdone_out_valid", 32'(b5.out_valid), 0);
        chk("rstdone_result", 32'(b5.result), 0);
        chk("rstdone_ill", 32'(b5.illegal_operation), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b5.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstdone_idle", 32'({b5.out_valid, b5.in_ready}), 1);

        // wide instance
        op8(255, 255, 2'b10);
        op8(200, 100, 2'b00);
        op8(16, 15, 2'b10);
        op8(77, 77, 2'b01);

        repeat (3) @(posedge clk);
        chk("sb5_drained", 32'(q5.size()), 0);
        chk("sb8_drained", 32'(q8.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
